// File: rtl/deserializador_alineado.sv
// Serial-to-parallel deserializer with comma-based word alignment.
// Searches for a comma, verifies LOCK_COUNT aligned commas, then delivers aligned words.
module deserializador_alineado #(
    parameter int              WIDTH      = 10,
    parameter logic [WIDTH-1:0] COMMA     = 10'b0011111010,
    parameter bit              DOBLE_DISP = 1'b1,
    parameter bit              MSB_FIRST  = 1'b1,
    parameter int              LOCK_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enb,
    input  logic             entrada,
    output logic [WIDTH-1:0] salidas,
    output logic             valido,
    output logic             alineado,
    output logic             comma_det
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [3:0]     LC   = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        BUSCAR    = 2'd0,
        VERIFICAR = 2'd1,
        ALINEADO  = 2'd2
    } estado_t;

    estado_t          est_q, est_d;
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       lock_q, lock_d;
    logic [WIDTH-1:0] sal_q, sal_d;
    logic             val_q, val_d;
    logic             al_q, al_d;
    logic             cd_q, cd_d;
    logic [WIDTH-1:0] ventana;
    logic             es_comma;
    logic             frontera;

    // The window always includes the bit being sampled, so a word completes with zero latency.
    generate
        if (MSB_FIRST) begin : g_msb
            assign ventana = {sr_q, entrada};
            assign sr_d    = enb ? ventana[WIDTH-2:0] : sr_q;
        end else begin : g_lsb
            assign ventana = {entrada, sr_q};
            assign sr_d    = enb ? ventana[WIDTH-1:1] : sr_q;
        end
    endgenerate

    assign es_comma = (ventana == COMMA) || (DOBLE_DISP && (ventana == ~COMMA));
    assign frontera = enb && (cnt_q == LAST);

    always_comb begin
        est_d  = est_q;
        cnt_d  = cnt_q;
        lock_d = lock_q;
        sal_d  = sal_q;
        val_d  = 1'b0;
        cd_d   = 1'b0;
        if (enb) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            case (est_q)
                BUSCAR: begin
                    if (es_comma) begin
                        cnt_d  = '0;
                        lock_d = 4'd1;
                        est_d  = (LOCK_COUNT == 1) ? ALINEADO : VERIFICAR;
                    end
                end
                VERIFICAR: begin
                    if (frontera) begin
                        if (es_comma) begin
                            lock_d = lock_q + 4'd1;
                            if (lock_d == LC) est_d = ALINEADO;
                        end else begin
                            est_d = BUSCAR;
                        end
                    end
                end
                ALINEADO: begin
                    if (frontera) begin
                        sal_d = ventana;
                        val_d = 1'b1;
                        cd_d  = es_comma;
                    end else if (es_comma) begin
                        // A comma off the word boundary means alignment was lost.
                        est_d = BUSCAR;
                    end
                end
                default: est_d = BUSCAR;
            endcase
        end
        al_d = (est_d == ALINEADO);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            est_q  <= BUSCAR;
            sr_q   <= '0;
            cnt_q  <= '0;
            lock_q <= '0;
            sal_q  <= '0;
            val_q  <= 1'b0;
            al_q   <= 1'b0;
            cd_q   <= 1'b0;
        end else begin
            est_q  <= est_d;
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
            sal_q  <= sal_d;
            val_q  <= val_d;
            al_q   <= al_d;
            cd_q   <= cd_d;
        end
    end

    assign salidas   = sal_q;
    assign valido    = val_q;
    assign alineado  = al_q;
    assign comma_det = cd_q;

endmodule
